ebi_tx_sched: RTL and testbench

- Transmit-side scheduler for the off-die EBI link.
- Arbitrates round-robin among per-channel transmit queues and hands one message at a time to the TX serializer.
- Holds the granted message until the far-end receiver returns a credit: SUCCESS pops the queue, FAILURE triggers retransmission.
- Tracks retries and flags a sticky link error when the retry budget is exhausted.

---
 rtl/ebi_tx_sched.sv | 147 ++++++++++++++
 tb/tb_ebi_tx_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ebi_tx_sched.sv
// ebi_tx_sched: transmit-side scheduler for the off-die EBI link.
// Round-robin grant among CH_NUM queue heads, one message outstanding,
// retransmit on FAILURE credit up to MAX_RETRY times, sticky link_err on drop.
// Optional credit-wait timeout: define EBI_TX_SCHED_TIMEOUT_EN.
module ebi_tx_sched #(
  parameter int CH_NUM         = 10,
  parameter int CH_ID_W        = 4,
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_W        = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_W      = 9
) (
  input  logic               if_clk,
  input  logic               rst,
  input  logic [CH_NUM-1:0]  ch_valid,
  output logic [CH_NUM-1:0]  ch_pop,
  output logic               tx_req,
  output logic [CH_ID_W-1:0] tx_ch_id,
  output logic               tx_retry,
  input  logic               tx_ack,
  input  logic               credit_valid,
  input  logic               credit_success,
  output logic               busy,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               link_err
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_CREDIT, DONE} state_t;

  localparam logic [CH_ID_W:0]   CH_NUM_X  = (CH_ID_W+1)'(CH_NUM);
  localparam logic [CH_ID_W-1:0] LAST_ID   = CH_ID_W'(CH_NUM - 1);
  localparam logic [RETRY_W-1:0] MAX_R     = RETRY_W'(MAX_RETRY);

  state_t               state_q, state_d;
  logic [CH_ID_W-1:0]   id_q, id_d;
  logic [CH_ID_W-1:0]   rr_q, rr_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 tx_retry_q, tx_retry_d;
  logic                 err_q, err_d;
  logic                 grant_vld;
  logic [CH_ID_W-1:0]   grant_id;
  logic                 tmo_exp;
  logic                 fail;

  // Cyclic search from rr_q; iterating downward leaves the nearest hit last.
  always_comb begin
    logic [CH_ID_W:0] idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + (CH_ID_W+1)'(k);
      if (idx >= CH_NUM_X) idx = idx - CH_NUM_X;
      if (ch_valid[idx[CH_ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = idx[CH_ID_W-1:0];
      end
    end
  end

`ifdef EBI_TX_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q;

  // Credit-wait counter: held at zero outside WAIT_CREDIT, so it restarts on every entry.
  always_ff @(posedge if_clk) begin
    if (rst || state_q != WAIT_CREDIT) tmo_q <= '0;
    else                               tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_exp = (state_q == WAIT_CREDIT) && (tmo_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_exp = 1'b0;
`endif

  // A real credit always wins over a coincident timeout.
  assign fail = credit_valid ? ~credit_success : tmo_exp;

  // State and context registers.
  always_ff @(posedge if_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      rr_q       <= '0;
      retry_q    <= '0;
      tx_retry_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      rr_q       <= rr_d;
      retry_q    <= retry_d;
      tx_retry_q <= tx_retry_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: grant, send handshake, credit resolution, pop.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    rr_d       = rr_q;
    retry_d    = retry_q;
    tx_retry_d = tx_retry_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          id_d       = grant_id;
          retry_d    = '0;
          tx_retry_d = 1'b0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ack) state_d = WAIT_CREDIT;
      end
      WAIT_CREDIT: begin
        if (credit_valid && credit_success) begin
          state_d = DONE;
        end else if (fail) begin
          if (retry_q < MAX_R) begin
            retry_d    = retry_q + 1'b1;
            tx_retry_d = 1'b1;
            state_d    = SEND;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        rr_d    = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_req    = (state_q == SEND);
  assign busy      = (state_q != IDLE);
  assign tx_ch_id  = id_q;
  assign tx_retry  = tx_retry_q;
  assign retry_cnt = retry_q;
  assign link_err  = err_q;
  assign ch_pop    = (state_q == DONE) ? ({{(CH_NUM-1){1'b0}}, 1'b1} << id_q) : '0;

endmodule

// File: tb/tb_ebi_tx_sched.sv
// Testbench for ebi_tx_sched: transaction-level reference model with
// randomized channel patterns, ack delays, failure counts and stray credits.
module tb_ebi_tx_sched;
  localparam int N = 10;
  localparam int MAXR = 3;

  logic          if_clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  ch_valid = '0;
  logic [N-1:0]  ch_pop;
  logic          tx_req;
  logic [3:0]    tx_ch_id;
  logic          tx_retry;
  logic          tx_ack = 1'b0;
  logic          credit_valid = 1'b0;
  logic          credit_success = 1'b0;
  logic          busy;
  logic [1:0]    retry_cnt;
  logic          link_err;

  int checks = 0;
  int failures = 0;
  int m_rr = 0;
  logic m_err = 1'b0;

  always #5 if_clk = ~if_clk;

  ebi_tx_sched #(
    .CH_NUM(N), .CH_ID_W(4), .MAX_RETRY(MAXR), .RETRY_W(2),
`ifdef EBI_TX_SCHED_TIMEOUT_EN
    .TIMEOUT_CYCLES(16), .TIMEOUT_W(5)
`else
    .TIMEOUT_CYCLES(256), .TIMEOUT_W(9)
`endif
  ) dut (
    .if_clk(if_clk), .rst(rst), .ch_valid(ch_valid), .ch_pop(ch_pop),
    .tx_req(tx_req), .tx_ch_id(tx_ch_id), .tx_retry(tx_retry), .tx_ack(tx_ack),
    .credit_valid(credit_valid), .credit_success(credit_success),
    .busy(busy), .retry_cnt(retry_cnt), .link_err(link_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge if_clk);
  endtask

  // Reference grant: first valid channel at or after rr, cyclically.
  function automatic int model_grant(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; ch_valid = '0; tx_ack = 1'b0; credit_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    m_rr = 0; m_err = 1'b0;
  endtask

  // One full message: grant, nfail FAILURE credits (capped by the retry budget),
  // then SUCCESS or drop. ack_dly<0 picks a random delay; stray credits during SEND.
  task automatic run_txn(input logic [N-1:0] v, input int nfail, input int ack_dly);
    int exp_id, waited, d, w;
    logic pass;
    ch_valid = v;
    exp_id = model_grant(v, m_rr);
    waited = 0;
    while (!tx_req && waited < 8) begin
      tick(); waited++;
    end
    chk("grant_latency", {31'b0, tx_req}, 32'd1);
    if (!tx_req) return;
    for (int a = 0; a <= MAXR; a++) begin
      chk("tx_req", {31'b0, tx_req}, 32'd1);
      chk("tx_ch_id", {28'b0, tx_ch_id}, exp_id);
      chk("tx_retry", {31'b0, tx_retry}, (a > 0) ? 32'd1 : 32'd0);
      chk("retry_cnt", {30'b0, retry_cnt}, a);
      d = (ack_dly < 0) ? $urandom_range(0, 3) : ack_dly;
      for (int i = 0; i < d; i++) begin
        credit_valid = ($urandom_range(0, 2) == 0);
        credit_success = $urandom_range(0, 1) != 0;
        tick();
        chk("req_hold", {31'b0, tx_req}, 32'd1);
        chk("id_hold", {28'b0, tx_ch_id}, exp_id);
        chk("no_pop_send", {22'b0, ch_pop}, 32'd0);
      end
      credit_valid = 1'b0;
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      chk("req_drop", {31'b0, tx_req}, 32'd0);
      w = $urandom_range(0, 5);
      for (int i = 0; i < w; i++) begin
        tick();
        chk("wait_idle", {31'b0, tx_req | (|ch_pop)}, 32'd0);
      end
      pass = (a >= nfail);
      credit_valid = 1'b1; credit_success = pass;
      tick();
      credit_valid = 1'b0;
      if (pass) break;
      if (a == MAXR) m_err = 1'b1;
    end
    chk("ch_pop", {22'b0, ch_pop}, 32'd1 << exp_id);
    chk("busy_done", {31'b0, busy}, 32'd1);
    tick();
    chk("pop_once", {22'b0, ch_pop}, 32'd0);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    m_rr = (exp_id + 1) % N;
    chk("rr_ptr", {28'b0, dut.rr_q}, m_rr);
    chk("link_err", {31'b0, link_err}, {31'b0, m_err});
  endtask

  initial begin
    do_reset();
    chk("rst_req", {31'b0, tx_req}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_id", {28'b0, tx_ch_id}, 0);
    chk("rst_retry", {30'b0, retry_cnt}, 0);
    chk("rst_err", {31'b0, link_err}, 0);
    chk("rst_pop", {22'b0, ch_pop}, 0);

    run_txn(10'b0000000100, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) run_txn(10'b1000000101, 0, -1);
    run_txn(10'b0000010000, 2, -1);
    run_txn(10'b0010000000, 4, -1);
    run_txn(10'b0000000010, 0, -1);
    run_txn(10'b0000100000, 0, 20);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(1, (1 << N) - 1));
      run_txn(v, $urandom_range(0, 4), -1);
    end

`ifdef EBI_TX_SCHED_TIMEOUT_EN
    do_reset();
    ch_valid = 10'b0001000000;
    tick();
    for (int a = 0; a <= MAXR; a++) begin
      chk("tmo_req", {31'b0, tx_req}, 1);
      chk("tmo_retry", {31'b0, tx_retry}, (a > 0) ? 32'd1 : 32'd0);
      tx_ack = 1'b1; tick(); tx_ack = 1'b0;
      for (int i = 0; i < 15; i++) begin
        chk("tmo_wait", {31'b0, tx_req}, 0);
        tick();
      end
    end
    chk("tmo_pop", {22'b0, ch_pop}, 32'd1 << 6);
    chk("tmo_err", {31'b0, link_err}, 1);
    tick();
`endif

    // Reset while waiting for a credit, with link_err already set.
    run_txn(10'b0000001000, 4, 0);
    ch_valid = 10'b0000001000;
    tick();
    chk("mid_req", {31'b0, tx_req}, 1);
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_req0", {31'b0, tx_req}, 0);
    chk("mid_busy0", {31'b0, busy}, 0);
    chk("mid_pop0", {22'b0, ch_pop}, 0);
    chk("mid_err0", {31'b0, link_err}, 0);
    chk("mid_id0", {28'b0, tx_ch_id}, 0);
    chk("mid_retry0", {30'b0, retry_cnt}, 0);
    chk("mid_rr0", {28'b0, dut.rr_q}, 0);
    rst = 1'b0; ch_valid = '0; m_rr = 0; m_err = 1'b0;
    tick();
    chk("post_pop0", {22'b0, ch_pop}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
